// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and hour constants for the parking gate block
// Purpose : FSM state and lane encodings plus the default opening hours,
//           shared by the gate sequencer and the occupancy block.
// Ports   : none (package)
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECIDE,
    OPEN,
    CLEAR
  } state_t;

  typedef enum logic {
    LANE_ENTRY,
    LANE_EXIT
  } lane_t;

  localparam int DEFAULT_OPEN_HOUR  = 8;
  localparam int DEFAULT_CLOSE_HOUR = 24;

endpackage

// File: rtl/parking_gate_sequencer_if.sv
// rtl/parking_gate_sequencer_if.sv - lane sensor / occupancy commit bundle
// Purpose : groups the lane sensors, admission flags, commit strobes and
//           gate drives between the sequencer and its surroundings.
// Ports   : slave  - sequencer view (sensors/flags in, strobes/gates out)
//           master - environment view (sensors/flags out, strobes/gates in)
interface parking_gate_sequencer_if;

  logic       entry_req;
  logic       entry_is_uni;
  logic       exit_req;
  logic       exit_is_uni;
  logic [5:0] hour;
  logic       uni_space_avail;
  logic       pub_space_avail;
  logic       car_entered;
  logic       is_uni_car_entered;
  logic       car_exited;
  logic       is_uni_car_exited;
  logic       entry_gate_open;
  logic       exit_gate_open;
  logic       entry_denied;
  logic       busy;
  logic       fault;

  modport slave (
    input  entry_req, entry_is_uni, exit_req, exit_is_uni, hour,
           uni_space_avail, pub_space_avail,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
           entry_gate_open, exit_gate_open, entry_denied, busy, fault
  );

  modport master (
    output entry_req, entry_is_uni, exit_req, exit_is_uni, hour,
           uni_space_avail, pub_space_avail,
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
           entry_gate_open, exit_gate_open, entry_denied, busy, fault
  );

endinterface

// File: rtl/parking_gate_sequencer_lane_arbiter.sv
// rtl/parking_gate_sequencer_lane_arbiter.sv - lane arming and 2-way round robin
// Purpose : turns level sensors into one-shot requests and picks a lane.
// Ports   : clk, rst_n          - clock, synchronous active-low reset
//           entry_req, exit_req - lane sensors (level)
//           grant_en            - sequencer is idle and can take a car
//           grant_valid         - a lane is granted this cycle
//           grant_lane          - which lane is granted
module lane_arbiter
  import parking_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  entry_req,
  input  logic  exit_req,
  input  logic  grant_en,
  output logic  grant_valid,
  output lane_t grant_lane
);

  logic  armed_entry_q, armed_entry_d;
  logic  armed_exit_q, armed_exit_d;
  lane_t last_served_q, last_served_d;
  logic  entry_pend, exit_pend;

  assign entry_pend = entry_req & armed_entry_q;
  assign exit_pend  = exit_req & armed_exit_q;

  always_comb begin
    grant_valid = grant_en & (entry_pend | exit_pend);
    grant_lane  = LANE_ENTRY;
    if (entry_pend && exit_pend) begin
      grant_lane = (last_served_q == LANE_ENTRY) ? LANE_EXIT : LANE_ENTRY;
    end else if (exit_pend) begin
      grant_lane = LANE_EXIT;
    end

    // A held sensor stays disarmed until it is released once.
    armed_entry_d = armed_entry_q;
    if (grant_valid && grant_lane == LANE_ENTRY) armed_entry_d = 1'b0;
    else if (!entry_req)                         armed_entry_d = 1'b1;

    armed_exit_d = armed_exit_q;
    if (grant_valid && grant_lane == LANE_EXIT) armed_exit_d = 1'b0;
    else if (!exit_req)                         armed_exit_d = 1'b1;

    last_served_d = grant_valid ? grant_lane : last_served_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_entry_q <= 1'b1;
      armed_exit_q  <= 1'b1;
      last_served_q <= LANE_EXIT;
    end else begin
      armed_entry_q <= armed_entry_d;
      armed_exit_q  <= armed_exit_d;
      last_served_q <= last_served_d;
    end
  end

endmodule

// File: rtl/parking_gate_sequencer.sv
// rtl/parking_gate_sequencer.sv - admission, commit strobes and barrier sequencing
// Purpose : serves one car at a time from the arbitrated lanes, decides
//           admission, strobes the occupancy block and drives the gates.
// Ports   : clk, rst_n - clock, synchronous active-low reset
//           bus        - sensors, flags, commit strobes, gate drives, status
module parking_gate_sequencer
  import parking_pkg::*;
#(
  parameter int GATE_OPEN_CYCLES = 8,
  parameter int CLEAR_TIMEOUT    = 64,
  parameter int OPEN_HOUR        = DEFAULT_OPEN_HOUR,
  parameter int CLOSE_HOUR       = DEFAULT_CLOSE_HOUR
) (
  input logic                      clk,
  input logic                      rst_n,
  parking_gate_sequencer_if.slave  bus
);

  localparam int MAX_CNT = (GATE_OPEN_CYCLES > CLEAR_TIMEOUT) ? GATE_OPEN_CYCLES : CLEAR_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] GATE_LOAD = CW'(GATE_OPEN_CYCLES);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_TIMEOUT - 1);
  localparam logic [6:0] OPEN_H  = 7'(OPEN_HOUR);
  localparam logic [6:0] CLOSE_H = 7'(CLOSE_HOUR);

  state_t        state_q, state_d;
  lane_t         lane_q, lane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          car_entered_q, car_entered_d;
  logic          car_exited_q, car_exited_d;
  logic          uni_ent_q, uni_ent_d;
  logic          uni_ext_q, uni_ext_d;
  logic          entry_gate_q, entry_gate_d;
  logic          exit_gate_q, exit_gate_d;
  logic          entry_denied_q, entry_denied_d;
  logic          fault_q, fault_d;

  logic          grant_valid;
  lane_t         grant_lane;
  logic [6:0]    hour_x;
  logic          lane_req;
  logic          admit;

  lane_arbiter u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .entry_req   (bus.entry_req),
    .exit_req    (bus.exit_req),
    .grant_en    (state_q == IDLE),
    .grant_valid (grant_valid),
    .grant_lane  (grant_lane)
  );

  assign hour_x   = {1'b0, bus.hour};
  assign lane_req = (lane_q == LANE_ENTRY) ? bus.entry_req : bus.exit_req;

  always_comb begin
    state_d        = state_q;
    lane_d         = lane_q;
    cnt_d          = cnt_q;
    car_entered_d  = 1'b0;
    car_exited_d   = 1'b0;
    entry_denied_d = 1'b0;
    uni_ent_d      = uni_ent_q;
    uni_ext_d      = uni_ext_q;
    entry_gate_d   = entry_gate_q;
    exit_gate_d    = exit_gate_q;
    fault_d        = fault_q;
    admit          = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          lane_d  = grant_lane;
          state_d = DECIDE;
          // The class register doubles as the held is_uni output.
          if (grant_lane == LANE_ENTRY) uni_ent_d = bus.entry_is_uni;
          else                          uni_ext_d = bus.exit_is_uni;
        end
      end
      DECIDE: begin
        if (lane_q == LANE_ENTRY) begin
          admit = (hour_x >= OPEN_H) && (hour_x < CLOSE_H) &&
                  (uni_ent_q ? (bus.uni_space_avail | bus.pub_space_avail)
                             : bus.pub_space_avail);
          if (admit) begin
            car_entered_d = 1'b1;
            entry_gate_d  = 1'b1;
            cnt_d         = GATE_LOAD;
            state_d       = OPEN;
          end else begin
            entry_denied_d = 1'b1;
            state_d        = IDLE;
          end
        end else begin
          // Exits are never denied visibly; before opening hour they just drop.
          if (hour_x >= OPEN_H) begin
            car_exited_d = 1'b1;
            exit_gate_d  = 1'b1;
            cnt_d        = GATE_LOAD;
            state_d      = OPEN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OPEN: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = CLEAR;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CLEAR: begin
        if (!lane_req) begin
          entry_gate_d = 1'b0;
          exit_gate_d  = 1'b0;
          state_d      = IDLE;
        end else if (cnt_q >= CLEAR_LAST) begin
          fault_d      = 1'b1;
          entry_gate_d = 1'b0;
          exit_gate_d  = 1'b0;
          state_d      = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lane_q         <= LANE_ENTRY;
      cnt_q          <= '0;
      car_entered_q  <= 1'b0;
      car_exited_q   <= 1'b0;
      uni_ent_q      <= 1'b0;
      uni_ext_q      <= 1'b0;
      entry_gate_q   <= 1'b0;
      exit_gate_q    <= 1'b0;
      entry_denied_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      lane_q         <= lane_d;
      cnt_q          <= cnt_d;
      car_entered_q  <= car_entered_d;
      car_exited_q   <= car_exited_d;
      uni_ent_q      <= uni_ent_d;
      uni_ext_q      <= uni_ext_d;
      entry_gate_q   <= entry_gate_d;
      exit_gate_q    <= exit_gate_d;
      entry_denied_q <= entry_denied_d;
      fault_q        <= fault_d;
    end
  end

  assign bus.car_entered        = car_entered_q;
  assign bus.is_uni_car_entered = uni_ent_q;
  assign bus.car_exited         = car_exited_q;
  assign bus.is_uni_car_exited  = uni_ext_q;
  assign bus.entry_gate_open    = entry_gate_q;
  assign bus.exit_gate_open     = exit_gate_q;
  assign bus.entry_denied       = entry_denied_q;
  assign bus.fault              = fault_q;
  assign bus.busy               = (state_q != IDLE);

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// tb/tb_parking_gate_sequencer.sv - self-checking bench for parking_gate_sequencer
module tb_parking_gate_sequencer;

  localparam int G  = 8;
  localparam int CT = 64;

  logic clk;
  logic rst_n;
  parking_gate_sequencer_if bus ();

  parking_gate_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Transaction-level model: a car is described by its age in cycles since grant.
  bit m_idle = 1'b1;
  int age    = 0;
  int m_lane = 0;
  int m_last = 1;
  bit m_armed [2] = '{1'b1, 1'b1};
  bit e_ce = 0, e_cx = 0, e_ue = 0, e_ux = 0, e_eg = 0, e_xg = 0, e_den = 0, e_fault = 0;

  always @(posedge clk) begin
    bit r [2];
    bit p0, p1, grant, open_hrs, ok;
    int gl;
    r[0] = bus.entry_req;
    r[1] = bus.exit_req;
    cyc++;
    e_ce = 0; e_cx = 0; e_den = 0; grant = 0; gl = 0;
    if (!rst_n) begin
      m_idle = 1; m_last = 1; m_armed[0] = 1; m_armed[1] = 1;
      e_ue = 0; e_ux = 0; e_eg = 0; e_xg = 0; e_fault = 0;
    end else begin
      if (m_idle) begin
        p0 = r[0] && m_armed[0];
        p1 = r[1] && m_armed[1];
        if (p0 || p1) begin
          grant = 1;
          gl = (p0 && p1) ? 1 - m_last : (p0 ? 0 : 1);
          m_lane = gl; m_last = gl; m_idle = 0; age = 0;
          if (gl == 0) e_ue = bus.entry_is_uni;
          else         e_ux = bus.exit_is_uni;
        end
      end else begin
        age++;
        if (age == 1) begin
          if (m_lane == 0) begin
            open_hrs = (bus.hour >= 8) && (bus.hour < 24);
            ok = open_hrs && (e_ue ? (bus.uni_space_avail || bus.pub_space_avail) : bus.pub_space_avail);
            if (ok) begin e_ce = 1; e_eg = 1; end
            else    begin e_den = 1; m_idle = 1; end
          end else begin
            if (bus.hour >= 8) begin e_cx = 1; e_xg = 1; end
            else m_idle = 1;
          end
        end else if (age > 1 + G) begin
          if (!r[m_lane]) begin
            e_eg = 0; e_xg = 0; m_idle = 1;
          end else if (age - 1 - G == CT) begin
            e_fault = 1; e_eg = 0; e_xg = 0; m_idle = 1;
          end
        end
      end
      for (int l = 0; l < 2; l++) begin
        if (grant && gl == l) m_armed[l] = 0;
        else if (!r[l])       m_armed[l] = 1;
      end
    end
  end

  // Event bookkeeping for the literal checks.
  int ent_n = 0, ext_n = 0, den_n = 0, eg_n = 0, xg_n = 0;
  int ent_cyc = -1, ext_cyc = -1, fault_cyc = -1;
  bit ent_uni = 0;

  always @(negedge clk) begin
    logic [8:0] exp_v, act_v;
    if (cyc > 0) begin
      exp_v = {e_ce, e_ue, e_cx, e_ux, e_eg, e_xg, e_den, !m_idle, e_fault};
      act_v = {bus.car_entered, bus.is_uni_car_entered, bus.car_exited, bus.is_uni_car_exited,
               bus.entry_gate_open, bus.exit_gate_open, bus.entry_denied, bus.busy, bus.fault};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL outputs cyc=%0d: got %b expected %b (ce,ue,cx,ux,eg,xg,den,busy,fault)", cyc, act_v, exp_v);
      end
      if (bus.car_entered) begin ent_n++; ent_cyc = cyc; ent_uni = bus.is_uni_car_entered; end
      if (bus.car_exited)  begin ext_n++; ext_cyc = cyc; end
      if (bus.entry_denied) den_n++;
      if (bus.entry_gate_open) eg_n++;
      if (bus.exit_gate_open)  xg_n++;
      if (bus.fault && fault_cyc < 0) fault_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 300) begin step(1); k++; end
    if (k >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles", bus.busy, k);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, s_ent, s_ext, s_den, s_eg, s_xg, k;
    rst_n = 0;
    bus.entry_req = 0; bus.entry_is_uni = 0; bus.exit_req = 0; bus.exit_is_uni = 0;
    bus.hour = 6'd9; bus.uni_space_avail = 0; bus.pub_space_avail = 1;
    step(3);
    rst_n = 1;
    step(2);
    chk("reset_busy", bus.busy, 0);
    chk("reset_gate", bus.entry_gate_open, 0);

    // Public entry during opening hours.
    s_eg = eg_n; r = cyc;
    bus.entry_req = 1;
    step(5);
    bus.entry_req = 0;
    wait_idle();
    chk("s1_strobe_cycle", ent_cyc, r + 2);
    chk("s1_gate_cycles", eg_n - s_eg, G + 1);
    chk("s1_busy_after", bus.busy, 0);
    step(2);

    // Before opening hour: one denial per sensor press.
    bus.hour = 6'd7;
    s_den = den_n; s_ent = ent_n; s_eg = eg_n;
    bus.entry_req = 1;
    step(20);
    chk("s2_one_denial", den_n - s_den, 1);
    chk("s2_no_entry", ent_n - s_ent, 0);
    chk("s2_gate_closed", eg_n - s_eg, 0);
    bus.entry_req = 0;
    step(2);
    bus.entry_req = 1;
    step(5);
    chk("s2_second_denial", den_n - s_den, 2);
    bus.entry_req = 0;
    step(2);

    // University car using a public space, then no space at all.
    bus.hour = 6'd14; bus.entry_is_uni = 1; bus.uni_space_avail = 0; bus.pub_space_avail = 1;
    s_ent = ent_n; s_den = den_n;
    bus.entry_req = 1;
    step(4);
    bus.entry_req = 0;
    wait_idle();
    chk("s3_uni_entered", ent_n - s_ent, 1);
    chk("s3_uni_class", ent_uni, 1);
    bus.pub_space_avail = 0;
    bus.entry_req = 1;
    step(4);
    bus.entry_req = 0;
    step(2);
    chk("s3_full_denied", den_n - s_den, 1);
    chk("s3_full_no_entry", ent_n - s_ent, 1);

    // Simultaneous requests after reset: entry first.
    rst_n = 0;
    step(2);
    rst_n = 1;
    step(1);
    bus.hour = 6'd10; bus.pub_space_avail = 1; bus.entry_is_uni = 0; bus.exit_is_uni = 1;
    s_ext = ext_n; r = cyc;
    bus.entry_req = 1; bus.exit_req = 1;
    step(5);
    bus.entry_req = 0;
    k = 0;
    while (ext_n == s_ext && k < 60) begin step(1); k++; end
    bus.exit_req = 0;
    wait_idle();
    chk("s4_entry_first", ent_cyc, r + 2);
    chk("s4_exit_second", ext_cyc, r + 13);
    chk("s4_spacing", ext_cyc - ent_cyc, G + 3);

    // Lone entry, then a tie: exit goes first.
    bus.entry_req = 1;
    step(4);
    bus.entry_req = 0;
    wait_idle();
    step(1);
    s_ent = ent_n; r = cyc;
    bus.entry_req = 1; bus.exit_req = 1;
    step(5);
    bus.exit_req = 0;
    k = 0;
    while (ent_n == s_ent && k < 60) begin step(1); k++; end
    bus.entry_req = 0;
    wait_idle();
    chk("s4_tie_exit_first", ext_cyc, r + 2);
    chk("s4_tie_entry_second", ent_cyc, r + 13);
    step(2);

    // Exit sensor stuck: clear timeout fault.
    s_ext = ext_n; s_xg = xg_n; r = cyc;
    bus.exit_req = 1;
    step(80);
    chk("s5_fault_cycle", fault_cyc, r + 2 + G + CT);
    chk("s5_one_exit", ext_n - s_ext, 1);
    chk("s5_gate_cycles", xg_n - s_xg, G + CT);
    chk("s5_gate_closed", bus.exit_gate_open, 0);
    bus.exit_req = 0;
    step(2);
    chk("s5_fault_sticky", bus.fault, 1);
    bus.exit_req = 1;
    step(3);
    bus.exit_req = 0;
    wait_idle();
    chk("s5_rearmed_exit", ext_n - s_ext, 2);
    chk("s5_fault_held", bus.fault, 1);

    // Reset in the middle of an open gate.
    s_ent = ent_n;
    bus.entry_req = 1;
    step(5);
    rst_n = 0;
    step(1);
    chk("s6_gate_low", bus.entry_gate_open, 0);
    chk("s6_busy_low", bus.busy, 0);
    chk("s6_fault_low", bus.fault, 0);
    rst_n = 1;
    bus.entry_req = 0;
    step(4);
    chk("s6_no_extra_strobe", ent_n - s_ent, 1);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parking_gate_sequencer.md
Name: parking_gate_sequencer

Overview:
- Synchronous controller between the entry/exit lane sensors and the parking occupancy counter block.
- Arbitrates the two lanes onto one shared commit path, one car transaction at a time.
- Decides admission from hour and space-available flags, emits the single-cycle enter/exit strobes the counter consumes, and sequences the barrier gates (open hold, clear wait, timeout fault).

Parameters:
- GATE_OPEN_CYCLES, 8, cycles a barrier is held open after commit (>=1).
- CLEAR_TIMEOUT, 64, max cycles to wait for lane sensor release before fault (>=1).
- OPEN_HOUR, 8, first hour at which transactions are accepted.
- CLOSE_HOUR, 24, hour at and after which entries are denied (exits still served).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- entry_req  in  1  entry lane car-present sensor, level
- entry_is_uni  in  1  entering car is university-permitted; sampled at grant
- exit_req  in  1  exit lane car-present sensor, level
- exit_is_uni  in  1  exiting car is university-permitted; sampled at grant
- hour  in  6  current hour, 0..63 (values >=24 treated as closed for entry)
- uni_space_avail  in  1  university zone has a free space
- pub_space_avail  in  1  public zone has a free space
- car_entered  out  1  one-cycle commit strobe to occupancy block
- is_uni_car_entered  out  1  class of committed entry; valid with car_entered, held until next entry grant
- car_exited  out  1  one-cycle commit strobe to occupancy block
- is_uni_car_exited  out  1  class of committed exit; valid with car_exited, held until next exit grant
- entry_gate_open  out  1  entry barrier drive
- exit_gate_open  out  1  exit barrier drive
- entry_denied  out  1  one-cycle pulse, entry rejected
- busy  out  1  FSM not in IDLE
- fault  out  1  sticky, clear-timeout occurred; cleared only by reset

Behaviour:
- Reset (rst_n=0 at clk edge):
  - FSM=IDLE.
  - All outputs 0.
  - Both lanes armed.
  - last_served=EXIT, so entry wins the first tie.
  - Reset mid-transaction aborts immediately: gates close, no strobe is issued.
- Arming:
  - A lane is pending when its req=1 and it is armed.
  - A lane disarms when it is granted.
  - A lane re-arms on the first cycle its req=0.
  - Effect: a held sensor yields exactly one transaction.
- States: IDLE, DECIDE, OPEN, CLEAR.
- IDLE:
  - No pending lane -> stay.
  - One pending -> grant it.
  - Both pending -> grant the lane != last_served.
  - On grant: latch lane and is_uni, set last_served, go to DECIDE. Grant takes 1 cycle.
- DECIDE (1 cycle):
  - Entry grant:
    - Rejected if hour<OPEN_HOUR or hour>=CLOSE_HOUR.
    - Otherwise admitted if uni: uni_space_avail|pub_space_avail; public: pub_space_avail.
    - Admitted -> car_entered=1 this cycle, is_uni_car_entered=latched class, go to OPEN.
    - Rejected -> entry_denied=1, back to IDLE, no gate motion.
  - Exit grant:
    - Admitted if hour>=OPEN_HOUR -> car_exited=1, go to OPEN.
    - Otherwise no strobe, return to IDLE, no denied pulse.
  - Availability flags are sampled only in DECIDE.
  - Strobe-to-strobe minimum spacing is GATE_OPEN_CYCLES+3 cycles.
- OPEN:
  - Granted lane's gate_open=1 for exactly GATE_OPEN_CYCLES cycles (down-counter, loaded in DECIDE), then go to CLEAR.
- CLEAR:
  - Gate stays open.
  - Granted lane req=0 -> close gate, go to IDLE.
  - Counter reaches CLEAR_TIMEOUT with req still 1 -> set fault, close gate, go to IDLE.
  - Lane stays disarmed until req drops.
- Simultaneous requests: exactly one strobe per transaction. car_entered and car_exited are never high in the same cycle.
- Counters: width $clog2(max(GATE_OPEN_CYCLES,CLEAR_TIMEOUT)+1), saturating, no wrap.
- Outputs are registered, except busy, which is decoded from state.

Decomposition:
- Shared package parking_pkg:
  - state enum (IDLE, DECIDE, OPEN, CLEAR).
  - lane enum (LANE_ENTRY, LANE_EXIT).
  - hour constants OPEN_HOUR/CLOSE_HOUR defaults, shared with the occupancy block.
- One natural sub-module: lane_arbiter, covering arming, 2-way round-robin and last_served. The FSM and timers stay in the top.

Test Plan:
- Reset, then entry_req=1, entry_is_uni=0, hour=9, pub_space_avail=1 -> car_entered pulse on cycle 2 after req, entry_gate_open high 8 cycles; drop req -> IDLE, busy=0.
- hour=7, entry_req=1 -> entry_denied single pulse, no car_entered, gate stays closed; holding req produces no second pulse until req drops and rises.
- Uni car, uni_space_avail=0, pub_space_avail=1, hour=14 -> car_entered=1 with is_uni_car_entered=1; both flags 0 -> entry_denied.
- entry_req and exit_req rise same cycle after reset -> entry served first, then exit; strobes separated by >=11 cycles, never coincident; repeat tie -> exit first.
- Exit granted, exit_req held high 80 cycles -> fault=1 after 64 CLEAR cycles, gate closes, no further exit until req toggles; fault stays set until rst_n=0.
- rst_n=0 during OPEN -> next cycle gates 0, state IDLE, fault 0, no extra strobe.
